// File: rtl/mhd_err_inj.sv
// Error injector: returns a copy of the input word with exactly min(k, WIDTH) bits flipped,
// with flip positions drawn from a 32-bit Galois LFSR.
module mhd_err_inj #(
    parameter int WIDTH = 129,
    parameter int CW    = 9,
    parameter int IW    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_load,
    input  logic [31:0]      seed,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CW-1:0]    in_k,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    out_dist
);

    typedef enum logic [1:0] {IDLE, BUSY, OUT} state_t;

    localparam logic [CW-1:0] WIDTH_CW = CW'(WIDTH);
    localparam logic [31:0]   POLY     = 32'h8020_0003;

    state_t           state, state_nx;
    logic [31:0]      lfsr, lfsr_nx, lfsr_step;
    logic [WIDTH-1:0] a_q, a_nx, mask_q, mask_nx;
    logic [CW-1:0]    count_q, count_nx, keff_q, keff_nx, k_sat;
    logic [IW-1:0]    idx;
    logic             hit;

    always_comb begin
        k_sat     = (in_k > WIDTH_CW) ? WIDTH_CW : in_k;
        lfsr_step = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? POLY : '0);
        idx       = lfsr_step[IW-1:0];
        // Out-of-range indices and already-flipped bits are simply skipped.
        hit       = (int'(idx) < WIDTH) && !mask_q[idx];
    end

    always_comb begin
        state_nx = state;
        lfsr_nx  = lfsr;
        a_nx     = a_q;
        mask_nx  = mask_q;
        count_nx = count_q;
        keff_nx  = keff_q;
        case (state)
            IDLE: begin
                if (seed_load)
                    lfsr_nx = (seed == '0) ? 32'h0000_0001 : seed;
                if (in_valid) begin
                    a_nx     = in_data;
                    keff_nx  = k_sat;
                    mask_nx  = '0;
                    count_nx = '0;
                    if (k_sat == '0) begin
                        state_nx = OUT;
                    end else if (k_sat == WIDTH_CW) begin
                        mask_nx  = '1;
                        count_nx = WIDTH_CW;
                        state_nx = OUT;
                    end else begin
                        state_nx = BUSY;
                    end
                end
            end
            BUSY: begin
                lfsr_nx = lfsr_step;
                if (hit) begin
                    mask_nx[idx] = 1'b1;
                    count_nx     = count_q + CW'(1);
                    if (count_q + CW'(1) == keff_q)
                        state_nx = OUT;
                end
            end
            OUT: begin
                if (out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lfsr    <= 32'h0000_0001;
            a_q     <= '0;
            mask_q  <= '0;
            count_q <= '0;
            keff_q  <= '0;
        end else begin
            state   <= state_nx;
            lfsr    <= lfsr_nx;
            a_q     <= a_nx;
            mask_q  <= mask_nx;
            count_q <= count_nx;
            keff_q  <= keff_nx;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign out_data  = a_q ^ mask_q;
    assign out_dist  = count_q;

endmodule
